// File: rtl/ide_cycle_ctrl.sv
// rtl/ide_cycle_ctrl.sv - IDE PIO cycle sequencer for a 68k-style CPU bus
//
// Converts a CPU access inside the IDE window into a timed drive cycle:
// address/select setup, strobe active (stretched by IORDY up to a cap),
// hold with DTACK until the CPU releases DS, then a recovery gap.
//
// Ports
//   CLKCPU      in   CPU clock, rising edge
//   RESET       in   synchronous reset, active low
//   IDE_SEL     in   IDE window decode, active low
//   DS          in   CPU data strobe, active low
//   RW          in   1 = read, 0 = write
//   A12         in   0 = command block (CS0), 1 = control block (CS1)
//   A[2:0]      in   drive register address
//   IORDY       in   drive ready, high = ready
//   IDE_CS0_N   out  command block select, active low
//   IDE_CS1_N   out  control block select, active low
//   IDE_DA[2:0] out  drive register address
//   IDE_DIOR_N  out  read strobe, active low
//   IDE_DIOW_N  out  write strobe, active low
//   DLATCH      out  read data latch pulse (final strobe cycle)
//   BUF_OE_N    out  data buffer enable, active low
//   BUF_DIR     out  1 = drive-to-CPU, 0 = CPU-to-drive
//   DTACK_N     out  CPU acknowledge, active low
//   TIMEOUT     out  one-cycle pulse when the IORDY wait hits its cap
module ide_cycle_ctrl #(
   parameter int T_SETUP   = 2,
   parameter int T_ACTIVE  = 6,
   parameter int T_RECOVER = 3,
   parameter int T_TIMEOUT = 255
) (
   input  logic       CLKCPU,
   input  logic       RESET,
   input  logic       IDE_SEL,
   input  logic       DS,
   input  logic       RW,
   input  logic       A12,
   input  logic [2:0] A,
   input  logic       IORDY,
   output logic       IDE_CS0_N,
   output logic       IDE_CS1_N,
   output logic [2:0] IDE_DA,
   output logic       IDE_DIOR_N,
   output logic       IDE_DIOW_N,
   output logic       DLATCH,
   output logic       BUF_OE_N,
   output logic       BUF_DIR,
   output logic       DTACK_N,
   output logic       TIMEOUT
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] SETUP   = 3'd1;
   localparam logic [2:0] ACTIVE  = 3'd2;
   localparam logic [2:0] HOLD    = 3'd3;
   localparam logic [2:0] RECOVER = 3'd4;

   localparam int CNT_MAX = T_SETUP + T_ACTIVE + T_TIMEOUT + T_RECOVER;
   localparam int CW = ($clog2(CNT_MAX + 1) < 8) ? 8 : $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] ONE     = CW'(1);
   localparam logic [CW-1:0] SET_END = CW'(T_SETUP - 1);
   localparam logic [CW-1:0] REC_END = CW'(T_RECOVER - 1);
   localparam logic [CW-1:0] ACT_MIN = CW'(T_ACTIVE - 1);
   localparam logic [CW-1:0] ACT_CAP = CW'(T_ACTIVE - 1 + T_TIMEOUT);

   logic [2:0]    st, nxt_st;
   logic [CW-1:0] cnt, nxt_cnt, act_n;
   logic          ds_q;
   logic          last_q, nxt_last;
   logic          to_q, nxt_to;
   logic          rw_q, nxt_rw;
   logic          a12_q, nxt_a12;
   logic [2:0]    a_q, nxt_a;
   logic          nxt_dlatch, nxt_timeout, nxt_busy;
   logic          act_last, enter_act;

   // Strobe outputs are registered, so the end of ACTIVE is decided one
   // cycle ahead: IORDY sampled on edge N makes the cycle after edge N the
   // last strobe cycle. That lets DLATCH sit on the final strobe cycle.
   always_comb begin
      nxt_st      = st;
      nxt_cnt     = cnt;
      nxt_last    = last_q;
      nxt_to      = to_q;
      nxt_rw      = rw_q;
      nxt_a12     = a12_q;
      nxt_a       = a_q;
      nxt_dlatch  = 1'b0;
      nxt_timeout = 1'b0;

      // act_n is the index of the strobe cycle about to begin
      act_n     = (st == SETUP) ? '0 : cnt + ONE;
      act_last  = (act_n >= ACT_MIN) && (IORDY || (act_n >= ACT_CAP));
      enter_act = ((st == SETUP) && (cnt == SET_END)) || ((st == ACTIVE) && !last_q);

      case (st)
         IDLE: begin
            // DS must be low on two consecutive edges to reject glitches
            if (!IDE_SEL && !DS && !ds_q) begin
               nxt_st  = SETUP;
               nxt_cnt = '0;
               nxt_rw  = RW;
               nxt_a12 = A12;
               nxt_a   = A;
            end
         end
         SETUP: begin
            if (cnt != SET_END) nxt_cnt = cnt + ONE;
         end
         ACTIVE: begin
            if (last_q) begin
               nxt_st      = HOLD;
               nxt_cnt     = '0;
               nxt_timeout = to_q;
               nxt_last    = 1'b0;
               nxt_to      = 1'b0;
            end
         end
         HOLD: begin
            // ds_q covers DS already high at HOLD entry: no DTACK, leave at once
            if (DS || ds_q) begin
               nxt_st  = RECOVER;
               nxt_cnt = '0;
            end
         end
         RECOVER: begin
            if (cnt == REC_END) begin
               nxt_st  = IDLE;
               nxt_cnt = '0;
            end else begin
               nxt_cnt = cnt + ONE;
            end
         end
         default: begin
            nxt_st  = IDLE;
            nxt_cnt = '0;
         end
      endcase

      if (enter_act) begin
         nxt_st     = ACTIVE;
         nxt_cnt    = act_n;
         nxt_last   = act_last;
         nxt_to     = act_last && !IORDY;
         nxt_dlatch = act_last && rw_q;
      end

      nxt_busy = (nxt_st == SETUP) || (nxt_st == ACTIVE) || (nxt_st == HOLD);
   end

   always_ff @(posedge CLKCPU) begin
      if (!RESET) begin
         st         <= IDLE;
         cnt        <= '0;
         ds_q       <= 1'b1;
         last_q     <= 1'b0;
         to_q       <= 1'b0;
         rw_q       <= 1'b0;
         a12_q      <= 1'b0;
         a_q        <= 3'd0;
         IDE_CS0_N  <= 1'b1;
         IDE_CS1_N  <= 1'b1;
         IDE_DA     <= 3'd0;
         IDE_DIOR_N <= 1'b1;
         IDE_DIOW_N <= 1'b1;
         DLATCH     <= 1'b0;
         BUF_OE_N   <= 1'b1;
         BUF_DIR    <= 1'b0;
         DTACK_N    <= 1'b1;
         TIMEOUT    <= 1'b0;
      end else begin
         st         <= nxt_st;
         cnt        <= nxt_cnt;
         ds_q       <= DS;
         last_q     <= nxt_last;
         to_q       <= nxt_to;
         rw_q       <= nxt_rw;
         a12_q      <= nxt_a12;
         a_q        <= nxt_a;
         IDE_CS0_N  <= !(nxt_busy && !nxt_a12);
         IDE_CS1_N  <= !(nxt_busy && nxt_a12);
         IDE_DA     <= nxt_a;
         IDE_DIOR_N <= !((nxt_st == ACTIVE) && nxt_rw);
         IDE_DIOW_N <= !((nxt_st == ACTIVE) && !nxt_rw);
         DLATCH     <= nxt_dlatch;
         BUF_OE_N   <= !nxt_busy;
         BUF_DIR    <= nxt_rw;
         DTACK_N    <= !((nxt_st == HOLD) && !DS);
         TIMEOUT    <= nxt_timeout;
      end
   end

endmodule

// File: tb/tb_ide_cycle_ctrl.sv
// tb/tb_ide_cycle_ctrl.sv - directed self-checking bench for ide_cycle_ctrl
module tb_ide_cycle_ctrl;

   localparam int T_ACTIVE = 6;

   logic       CLKCPU = 1'b0;
   logic       RESET, IDE_SEL, DS, RW, A12, IORDY;
   logic [2:0] A;
   logic       IDE_CS0_N, IDE_CS1_N, IDE_DIOR_N, IDE_DIOW_N;
   logic       DLATCH, BUF_OE_N, BUF_DIR, DTACK_N, TIMEOUT;
   logic [2:0] IDE_DA;

   int passed = 0;
   int failed = 0;
   int total  = 0;

   int m_pre, m_setup, m_strobe, m_dl, m_dl_idx, m_to, m_to_at, m_dtack, m_bad;
   logic m_done;

   ide_cycle_ctrl dut (
      .CLKCPU(CLKCPU), .RESET(RESET), .IDE_SEL(IDE_SEL), .DS(DS), .RW(RW),
      .A12(A12), .A(A), .IORDY(IORDY),
      .IDE_CS0_N(IDE_CS0_N), .IDE_CS1_N(IDE_CS1_N), .IDE_DA(IDE_DA),
      .IDE_DIOR_N(IDE_DIOR_N), .IDE_DIOW_N(IDE_DIOW_N), .DLATCH(DLATCH),
      .BUF_OE_N(BUF_OE_N), .BUF_DIR(BUF_DIR), .DTACK_N(DTACK_N), .TIMEOUT(TIMEOUT)
   );

   always #5 CLKCPU = ~CLKCPU;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      IDE_SEL = 1'b1;
      DS      = 1'b1;
      repeat (n) @(negedge CLKCPU);
   endtask

   // Runs one CPU access and tallies what the drive-side pins did.
   task automatic access(input logic rw_i, input logic a12_i, input logic [2:0] a_i,
                         input int wait_extra, input int hold_ds, input bit early);
      logic sel_cs, oth_cs, strb, oth_strb;
      m_pre = 0; m_setup = 0; m_strobe = 0; m_dl = 0; m_dl_idx = 0;
      m_to = 0; m_to_at = 0; m_dtack = 0; m_bad = 0; m_done = 1'b0;
      RW = rw_i; A12 = a12_i; A = a_i; IDE_SEL = 1'b0; DS = 1'b0;
      IORDY = (wait_extra == 0);
      for (int i = 0; i < 2000 && !m_done; i++) begin
         @(negedge CLKCPU);
         sel_cs   = a12_i ? IDE_CS1_N : IDE_CS0_N;
         oth_cs   = a12_i ? IDE_CS0_N : IDE_CS1_N;
         strb     = rw_i ? IDE_DIOR_N : IDE_DIOW_N;
         oth_strb = rw_i ? IDE_DIOW_N : IDE_DIOR_N;
         if (oth_cs !== 1'b1 || oth_strb !== 1'b1) m_bad++;
         if (sel_cs === 1'b0 && (IDE_DA !== a_i || BUF_DIR !== rw_i || BUF_OE_N !== 1'b0)) m_bad++;
         if (strb === 1'b0) m_strobe++;
         else if (m_strobe == 0) begin
            m_pre++;
            if (sel_cs === 1'b0) m_setup++;
         end
         if (DLATCH === 1'b1) begin m_dl++; m_dl_idx = m_strobe; end
         if (TIMEOUT === 1'b1) begin m_to++; m_to_at = m_strobe; end
         if (DTACK_N === 1'b0) m_dtack++;
         if (wait_extra > 0 && m_strobe == T_ACTIVE - 1 + wait_extra) IORDY = 1'b1;
         if (early && m_setup == 1) begin DS = 1'b1; IDE_SEL = 1'b1; end
         if (!early && hold_ds > 0 && m_dtack == hold_ds) begin DS = 1'b1; IDE_SEL = 1'b1; end
         if (m_strobe > 0 && sel_cs === 1'b1) m_done = 1'b1;
      end
      IORDY = 1'b1;
   endtask

   task automatic check_access(input string tag, input int pre, input int strobe,
                               input int dl, input int dl_idx, input int to, input int dtack);
      chk({tag, ".done"},   32'(m_done),   32'd1);
      chk({tag, ".pre"},    m_pre,    pre);
      chk({tag, ".setup"},  m_setup,  2);
      chk({tag, ".strobe"}, m_strobe, strobe);
      chk({tag, ".dlatch"}, m_dl,     dl);
      chk({tag, ".dl_idx"}, m_dl_idx, dl_idx);
      chk({tag, ".timeout"}, m_to,    to);
      chk({tag, ".dtack"},  m_dtack,  dtack);
      chk({tag, ".pins"},   m_bad,    0);
   endtask

   initial begin
      int   cnt;
      logic ok;
      RESET = 1'b0; IDE_SEL = 1'b1; DS = 1'b1; RW = 1'b0; A12 = 1'b0; A = 3'd0; IORDY = 1'b1;
      repeat (3) @(negedge CLKCPU);
      chk("reset.outputs",
          {IDE_CS0_N, IDE_CS1_N, IDE_DIOR_N, IDE_DIOW_N, BUF_OE_N, DTACK_N, IDE_DA, BUF_DIR, DLATCH, TIMEOUT},
          12'b111111_000_0_0_0);
      RESET = 1'b1;
      idle(3);

      // basic read, command block
      access(1'b1, 1'b0, 3'd7, 0, 3, 1'b0);
      check_access("read", 3, 6, 1, 6, 0, 3);
      idle(6);

      // basic write, control block
      access(1'b0, 1'b1, 3'd6, 0, 2, 1'b0);
      check_access("write", 3, 6, 0, 0, 0, 2);
      idle(6);

      // IORDY low for 10 cycles past the minimum
      access(1'b0, 1'b0, 3'd2, 10, 1, 1'b0);
      check_access("wait10", 3, 16, 0, 0, 0, 1);
      idle(6);

      // IORDY stuck low: strobe capped at 6+255 cycles
      access(1'b1, 1'b1, 3'd5, 100000, 2, 1'b0);
      check_access("tmo", 3, 261, 1, 261, 1, 2);
      chk("tmo.at", m_to_at, 261);
      idle(6);

      // DS released during SETUP: full cycle, no DTACK
      access(1'b1, 1'b1, 3'd3, 0, 0, 1'b1);
      check_access("early_ds", 3, 6, 1, 6, 0, 0);
      idle(6);

      // back-to-back: DS low again during RECOVER
      access(1'b1, 1'b0, 3'd1, 0, 1, 1'b0);
      check_access("b2b1", 3, 6, 1, 6, 0, 1);
      access(1'b1, 1'b0, 3'd4, 0, 1, 1'b0);
      check_access("b2b2", 5, 6, 1, 6, 0, 1);
      idle(6);

      // single-cycle DS glitch starts nothing
      IDE_SEL = 1'b0; DS = 1'b0;
      @(negedge CLKCPU);
      DS = 1'b1;
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge CLKCPU);
         if ({IDE_CS0_N, IDE_CS1_N, IDE_DIOR_N, IDE_DIOW_N, BUF_OE_N} !== 5'h1f) cnt++;
      end
      chk("glitch.idle", cnt, 0);
      idle(2);

      // reset in the third strobe cycle
      RW = 1'b1; A12 = 1'b0; A = 3'd0; IDE_SEL = 1'b0; DS = 1'b0;
      cnt = 0; ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge CLKCPU);
         if (IDE_DIOR_N === 1'b0) cnt++;
         if (cnt == 3) ok = 1'b1;
      end
      chk("rst.reach", 32'(ok), 32'd1);
      RESET = 1'b0;
      @(negedge CLKCPU);
      chk("rst.pins", {IDE_CS0_N, IDE_CS1_N, IDE_DIOR_N, IDE_DIOW_N, BUF_OE_N, DTACK_N}, 6'h3f);
      chk("rst.dlatch", 32'(DLATCH), 32'd0);
      RESET = 1'b1;
      idle(4);
      access(1'b1, 1'b0, 3'd7, 0, 2, 1'b0);
      check_access("after_rst", 3, 6, 1, 6, 0, 2);
      idle(4);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
